// File: rtl/ram_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-ported RAM; ARB_AGING_EN adds I-fetch anti-starvation.
// Latency: request in IDLE at n -> strobe at n+1 -> ready pulse at n+2 when busy_o is low at n+1.
// Backpressure: busy_o holds the strobe, address and store data without timeout; requesters hold until their ready pulse.
module ram_arbiter #(
  parameter int unsigned AGE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic        busy_o,
  input  logic [31:0] ramload,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        i_ready,
  output logic        d_ready,
  output logic [31:0] imemload,
  output logic [31:0] dmmload
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_bad_age_limit
    $error("ram_arbiter: AGE_LIMIT must be in 1..15");
  end

  logic [1:0] state;
  logic       d_req;
  logic       force_i;
  logic       grant_d;
  logic       grant_i;

  assign d_req   = dmmRen | dmmWen;
  assign grant_d = (state == IDLE) && d_req && !force_i;
  assign grant_i = (state == IDLE) && imemRen && !grant_d;

`ifdef ARB_AGING_EN
  localparam logic [3:0] AGE_LIM4 = 4'(AGE_LIMIT);
  logic [3:0] age_cnt;

  assign force_i = imemRen && (age_cnt >= AGE_LIM4);

  // Counts data grants that overtook a waiting fetch; saturates so it never wraps back to 0.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      age_cnt <= '0;
    end else if (grant_i) begin
      age_cnt <= '0;
    end else if (grant_d && imemRen && age_cnt != 4'd15) begin
      age_cnt <= age_cnt + 4'd1;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state    <= IDLE;
      Ren      <= 1'b0;
      Wen      <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      imemload <= '0;
      dmmload  <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= GNT_D;
            ramaddr  <= dmmaddr;
            ramstore <= dmmstore;
            Wen      <= dmmWen;
            Ren      <= ~dmmWen;  // read+write together resolves to a write
          end else if (grant_i) begin
            state    <= GNT_I;
            ramaddr  <= imemaddr;
            ramstore <= '0;
            Ren      <= 1'b1;
            Wen      <= 1'b0;
          end
        end
        GNT_I: begin
          if (!busy_o) begin
            imemload <= ramload;
            i_ready  <= 1'b1;
            Ren      <= 1'b0;
            Wen      <= 1'b0;
            state    <= IDLE;
          end
        end
        GNT_D: begin
          if (!busy_o) begin
            if (Ren) dmmload <= ramload;
            d_ready <= 1'b1;
            Ren     <= 1'b0;
            Wen     <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          Ren   <= 1'b0;
          Wen   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, fetch/read/write timing, priority, aging order and mid-grant reset.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic        busy_o;
  logic [31:0] ramload;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.AGE_LIMIT(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .busy_o(busy_o), .ramload(ramload),
    .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
    .i_ready(i_ready), .d_ready(d_ready), .imemload(imemload), .dmmload(dmmload)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b1; imemRen = 1'b0; imemaddr = '0; dmmRen = 1'b0; dmmWen = 1'b0;
    dmmaddr = '0; dmmstore = '0; busy_o = 1'b0; ramload = '0;
    step(); step();
    n_cmp++; if ({Ren, Wen, i_ready, d_ready} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes got %b want 0000", {Ren, Wen, i_ready, d_ready}); end
    n_cmp++; if (ramaddr !== 32'h0) begin n_bad++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
    n_cmp++; if (ramstore !== 32'h0) begin n_bad++; $display("FAIL reset_ramstore got %h want 0", ramstore); end
    n_cmp++; if ({imemload, dmmload} !== 64'h0) begin n_bad++; $display("FAIL reset_loads got %h/%h want 0/0", imemload, dmmload); end
    nRST = 1'b0;
  endtask

  task automatic test_fetch();
    imemRen = 1'b1; imemaddr = 32'h100; busy_o = 1'b0; ramload = 32'hDEADBEEF;
    step();
    n_cmp++; if ({Ren, Wen} !== 2'b10 || ramaddr !== 32'h100) begin n_bad++; $display("FAIL fetch_strobe got Ren/Wen=%b addr=%h want 10/100", {Ren, Wen}, ramaddr); end
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ready got %b want 0", i_ready); end
    step();
    n_cmp++; if (i_ready !== 1'b1 || imemload !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_ready got rdy=%b load=%h want 1/deadbeef", i_ready, imemload); end
    n_cmp++; if (Ren !== 1'b0) begin n_bad++; $display("FAIL fetch_strobe_drop got %b want 0", Ren); end
    imemRen = 1'b0;
    step();
    n_cmp++; if ({Ren, Wen, i_ready} !== 3'b000) begin n_bad++; $display("FAIL fetch_quiet got %b want 000", {Ren, Wen, i_ready}); end
  endtask

  task automatic test_write_busy();
    dmmWen = 1'b1; dmmaddr = 32'h200; dmmstore = 32'h12345678; busy_o = 1'b1; ramload = 32'hAAAA5555;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({Ren, Wen} !== 2'b01 || ramaddr !== 32'h200 || ramstore !== 32'h12345678 || d_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL write_hold[%0d] got RW=%b addr=%h store=%h rdy=%b want 01/200/12345678/0", i, {Ren, Wen}, ramaddr, ramstore, d_ready);
      end
      if (i == 3) busy_o = 1'b0;
    end
    step();
    n_cmp++; if (d_ready !== 1'b1 || Wen !== 1'b0) begin n_bad++; $display("FAIL write_done got rdy=%b Wen=%b want 1/0", d_ready, Wen); end
    n_cmp++; if (dmmload !== 32'h0) begin n_bad++; $display("FAIL write_dmmload got %h want 0", dmmload); end
    dmmWen = 1'b0;
    step();
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL write_single_ready got %b want 0", d_ready); end
  endtask

  task automatic test_read_and_rw();
    dmmRen = 1'b1; dmmaddr = 32'h240; busy_o = 1'b0; ramload = 32'hCAFEF00D;
    step();
    n_cmp++; if ({Ren, Wen} !== 2'b10) begin n_bad++; $display("FAIL dread_strobe got %b want 10", {Ren, Wen}); end
    step();
    n_cmp++; if (d_ready !== 1'b1 || dmmload !== 32'hCAFEF00D) begin n_bad++; $display("FAIL dread_done got rdy=%b load=%h want 1/cafef00d", d_ready, dmmload); end
    dmmRen = 1'b0;
    step();
    dmmRen = 1'b1; dmmWen = 1'b1; dmmstore = 32'h0000BEEF; ramload = 32'h0BADBEEF;
    step();
    n_cmp++; if ({Ren, Wen} !== 2'b01 || ramstore !== 32'h0000BEEF) begin n_bad++; $display("FAIL rw_is_write got RW=%b store=%h want 01/0000beef", {Ren, Wen}, ramstore); end
    step();
    n_cmp++; if (d_ready !== 1'b1 || dmmload !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rw_keeps_load got rdy=%b load=%h want 1/cafef00d", d_ready, dmmload); end
    dmmRen = 1'b0; dmmWen = 1'b0;
    step();
  endtask

  task automatic test_priority();
    imemRen = 1'b1; imemaddr = 32'h300; dmmRen = 1'b1; dmmaddr = 32'h400; busy_o = 1'b0; ramload = 32'h11112222;
    step();
    n_cmp++; if (Ren !== 1'b1 || ramaddr !== 32'h400) begin n_bad++; $display("FAIL prio_d_first got Ren=%b addr=%h want 1/400", Ren, ramaddr); end
    step();
    n_cmp++; if (d_ready !== 1'b1 || Ren !== 1'b0) begin n_bad++; $display("FAIL prio_turnaround got rdy=%b Ren=%b want 1/0", d_ready, Ren); end
    dmmRen = 1'b0;
    step();
    n_cmp++; if (Ren !== 1'b1 || ramaddr !== 32'h300) begin n_bad++; $display("FAIL prio_i_second got Ren=%b addr=%h want 1/300", Ren, ramaddr); end
    step();
    n_cmp++; if (i_ready !== 1'b1 || imemload !== 32'h11112222) begin n_bad++; $display("FAIL prio_i_done got rdy=%b load=%h want 1/11112222", i_ready, imemload); end
    imemRen = 1'b0;
    step();
  endtask

  task automatic test_aging();
    logic [31:0] exp_addr [8];
    int g;
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_AGING_EN
      exp_addr[i] = (i == 3 || i == 7) ? 32'h500 : 32'h600;
`else
      exp_addr[i] = 32'h600;
`endif
    end
    nRST = 1'b1;
    step();
    nRST = 1'b0; imemRen = 1'b1; imemaddr = 32'h500; dmmRen = 1'b1; dmmaddr = 32'h600; busy_o = 1'b0;
    g = 0;
    for (int c = 0; c < 40 && g < 8; c++) begin
      step();
      if (Ren || Wen) begin
        n_cmp++;
        if (ramaddr !== exp_addr[g]) begin n_bad++; $display("FAIL aging_grant[%0d] got addr=%h want %h", g, ramaddr, exp_addr[g]); end
        g++;
      end
    end
    n_cmp++; if (g != 8) begin n_bad++; $display("FAIL aging_grant_count got %0d want 8", g); end
    imemRen = 1'b0; dmmRen = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset_mid_grant();
    dmmWen = 1'b1; dmmaddr = 32'h700; dmmstore = 32'h55; busy_o = 1'b1;
    step();
    n_cmp++; if (Wen !== 1'b1) begin n_bad++; $display("FAIL rmid_granted got Wen=%b want 1", Wen); end
    nRST = 1'b1;
    step();
    n_cmp++; if ({Ren, Wen, d_ready, i_ready} !== 4'b0000) begin n_bad++; $display("FAIL rmid_strobes got %b want 0000", {Ren, Wen, d_ready, i_ready}); end
    n_cmp++; if ({ramaddr, ramstore, imemload, dmmload} !== 128'h0) begin n_bad++; $display("FAIL rmid_regs got %h/%h/%h/%h want zeros", ramaddr, ramstore, imemload, dmmload); end
    nRST = 1'b0; dmmWen = 1'b0; busy_o = 1'b0; imemRen = 1'b1; imemaddr = 32'h800; ramload = 32'h13572468;
    step();
    n_cmp++; if (Ren !== 1'b1 || ramaddr !== 32'h800 || d_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_first_grant got Ren=%b addr=%h drdy=%b want 1/800/0", Ren, ramaddr, d_ready); end
    step();
    n_cmp++; if (i_ready !== 1'b1 || imemload !== 32'h13572468 || d_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_first_done got irdy=%b load=%h drdy=%b want 1/13572468/0", i_ready, imemload, d_ready); end
    imemRen = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_busy();
    test_read_and_rw();
    test_priority();
    test_aging();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: AGE_LIMIT, 3, max consecutive data grants while an instruction request waits (range 1-15).
REQ-002 SHALL have port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: nRST  in  1  reset; synchronous, active-high (1 = reset, sampled on CLK rising edge).
REQ-004 SHALL have port: imemRen  in  1  instruction fetch request, held until i_ready.
REQ-005 SHALL have port: imemaddr  in  32  instruction fetch address.
REQ-006 SHALL have port: dmmRen  in  1  data read request, held until d_ready.
REQ-007 SHALL have port: dmmWen  in  1  data write request, held until d_ready.
REQ-008 SHALL have port: dmmaddr  in  32  data address.
REQ-009 SHALL have port: dmmstore  in  32  data write value.
REQ-010 SHALL have port: busy_o  in  1  RAM busy; 0 = current access completes this cycle.
REQ-011 SHALL have port: ramload  in  32  RAM read data, valid when busy_o = 0.
REQ-012 SHALL have ports: Ren, Wen  out  1  RAM read/write strobes (registered).
REQ-013 SHALL have ports: ramaddr, ramstore  out  32  RAM address/write data (registered).
REQ-014 SHALL have ports: i_ready, d_ready  out  1  one-cycle completion pulses.
REQ-015 SHALL have ports: imemload, dmmload  out  32  registered read data per requester.

Function
REQ-016 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-017 IDLE: SHALL grant D if (dmmRen|dmmWen) and not aged-out, else I if imemRen, else stay IDLE.
REQ-018 Grant SHALL latch address, store data and op into RAM output registers; the next cycle Ren or Wen is 1.
REQ-019 GNT_x: SHALL hold Ren/Wen/ramaddr/ramstore stable while busy_o = 1, with no timeout.
REQ-020 GNT_x with busy_o = 0: SHALL capture ramload into imemload/dmmload (reads only), pulse i_ready/d_ready next cycle, and drop Ren/Wen and return to IDLE.
REQ-021 Minimum latency SHALL be: request seen in IDLE at cycle n, strobe at n+1, ready at n+2 if busy_o = 0 at n+1.
REQ-022 SHALL insert one IDLE turnaround cycle between consecutive grants (no back-to-back strobes).
REQ-023 dmmRen and dmmWen both 1 SHALL be treated as a write; dmmload SHALL be unchanged.
REQ-024 A request withdrawn during grant SHALL still complete; the ready pulse SHALL still be issued.
REQ-025 imemload/dmmload SHALL hold their value until the next read completion on the same port; a write SHALL never alter dmmload.
REQ-026 Ren and Wen SHALL never both be 1.

Reset
REQ-027 nRST = 1 SHALL force IDLE; Ren, Wen, i_ready, d_ready = 0; ramaddr, ramstore, imemload, dmmload = 0; age counter = 0.
REQ-028 Reset mid-grant SHALL abandon the access with no ready pulse; the first grant is possible in the cycle after nRST falls.

Configuration
REQ-029 With ARB_AGING_EN defined: a 4-bit age counter SHALL increment on each D grant while imemRen = 1, clear on each I grant, and saturate at 15.
REQ-030 With ARB_AGING_EN defined: a counter value >= AGE_LIMIT with imemRen = 1 SHALL force the next grant to I.
REQ-031 Without ARB_AGING_EN: SHALL use strict data priority with no counter logic.

Verification
REQ-032 Fetch only, imemaddr=0x100, busy_o=0, ramload=0xDEADBEEF -> Ren=1/ramaddr=0x100 at n+1, i_ready=1 and imemload=0xDEADBEEF at n+2.
REQ-033 Write dmmaddr=0x200, dmmstore=0x12345678, busy_o=1 for 3 cycles -> Wen held 4 cycles with stable ramstore, single d_ready, dmmload unchanged.
REQ-034 imemRen and dmmRen asserted together in IDLE -> D granted first, I granted after one turnaround cycle.
REQ-035 ARB_AGING_EN, AGE_LIMIT=3, continuous D and I requests -> grant order D,D,D,I,D,D,D,I; without the macro -> I never granted.
REQ-036 nRST=1 during GNT_D with busy_o=1 -> next cycle Ren=Wen=0, no d_ready, FSM in IDLE, all outputs zero.
